pwm_gen: RTL

PWM waveform stage that sits directly downstream of the prescaler timer. It consumes the timer's one-clock `done` pulse as a count-enable tick and runs an R-bit period counter. It drives `pwm_out` high for `duty` ticks out of every `period+1` ticks. Duty and period changes are double-buffered and only take effect on a period boundary, so the output never glitches mid-period.

---
 rtl/pwm_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pwm_gen.sv
// pwm_gen
//   PWM waveform stage fed by a prescaler timer. Each `tick` advances an R-bit
//   period counter. `pwm_out` is high for `duty` ticks out of every `period+1`.
//   Duty/period updates are double-buffered. A new configuration captured while
//   running takes effect only at a period boundary, so the waveform never
//   glitches mid-period.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active low
//   tick         count enable (one pulse = one count)
//   en           run enable; low holds the block idle
//   cfg_load     one-clock strobe capturing duty/period
//   duty         requested high time in ticks
//   period       requested period minus one, in ticks
//   pwm_out      registered PWM waveform
//   period_end   one-clock pulse on the edge where the counter wraps
//   cfg_pending  high while a captured configuration waits for a boundary
module pwm_gen #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         en,
  input  logic         cfg_load,
  input  logic [R-1:0] duty,
  input  logic [R-1:0] period,
  output logic         pwm_out,
  output logic         period_end,
  output logic         cfg_pending
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [R-1:0] cnt_q, cnt_d;
  logic [R-1:0] duty_act_q, duty_act_d;
  logic [R-1:0] per_act_q, per_act_d;
  logic [R-1:0] duty_pnd_q, duty_pnd_d;
  logic [R-1:0] per_pnd_q, per_pnd_d;
  logic         pnd_d;
  logic         pwm_d;
  logic         pe_d;

  // Unsigned compare; duty >= period+1 naturally yields constant high.
  function automatic logic pwm_level(input logic [R-1:0] c, input logic [R-1:0] d);
    return (c < d);
  endfunction

  // Next-state / next-value logic
  always_comb begin
    state_d    = en ? RUN : IDLE;
    cnt_d      = cnt_q;
    duty_act_d = duty_act_q;
    per_act_d  = per_act_q;
    duty_pnd_d = duty_pnd_q;
    per_pnd_d  = per_pnd_q;
    pnd_d      = cfg_pending;
    pwm_d      = pwm_out;
    pe_d       = 1'b0;

    if (!en) begin
      // Idle: counter and output parked; loads go straight to the active pair.
      // A direct load supersedes any configuration left pending from RUN.
      cnt_d = '0;
      pwm_d = 1'b0;
      if (cfg_load) begin
        duty_act_d = duty;
        per_act_d  = period;
        pnd_d      = 1'b0;
      end
    end else if (state_q == IDLE) begin
      // Entry edge into RUN: counter starts at 0 and this edge does not count
      // a tick. Any configuration left pending is applied here.
      cnt_d = '0;
      if (cfg_load) begin
        duty_act_d = duty;
        per_act_d  = period;
        pnd_d      = 1'b0;
      end else if (cfg_pending) begin
        duty_act_d = duty_pnd_q;
        per_act_d  = per_pnd_q;
        pnd_d      = 1'b0;
      end
      pwm_d = pwm_level(cnt_d, duty_act_d);
    end else begin
      if (tick && (cnt_q == per_act_q)) begin
        // Boundary: wrap and switch configuration. A load on this same cycle
        // bypasses the pending pair.
        cnt_d = '0;
        pe_d  = 1'b1;
        if (cfg_load) begin
          duty_act_d = duty;
          per_act_d  = period;
          pnd_d      = 1'b0;
        end else if (cfg_pending) begin
          duty_act_d = duty_pnd_q;
          per_act_d  = per_pnd_q;
          pnd_d      = 1'b0;
        end
      end else begin
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cfg_load) begin
          duty_pnd_d = duty;
          per_pnd_d  = period;
          pnd_d      = 1'b1;
        end
      end
      pwm_d = pwm_level(cnt_d, duty_act_d);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      duty_act_q  <= '0;
      per_act_q   <= '1;
      duty_pnd_q  <= '0;
      per_pnd_q   <= '0;
      cfg_pending <= 1'b0;
      pwm_out     <= 1'b0;
      period_end  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_act_q  <= duty_act_d;
      per_act_q   <= per_act_d;
      duty_pnd_q  <= duty_pnd_d;
      per_pnd_q   <= per_pnd_d;
      cfg_pending <= pnd_d;
      pwm_out     <= pwm_d;
      period_end  <= pe_d;
    end
  end

endmodule
